// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path: opcodes, FSM states
// and the datapath select values driven by main_fsm.
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_R_TYPE = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_BEQ    = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECUTER,
      S_EXECUTEI,
      S_ALUWB,
      S_BEQ,
      S_JAL
   } state_t;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_REG   = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decode: immediate format select and legal-opcode check.
// jal is only recognised when MAIN_FSM_JAL_EN is defined.
module instr_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] i_opcode,
   output logic [1:0] o_immSrc,
   output logic       o_legal
);

   always_comb begin
      o_immSrc = IMM_I;
      o_legal  = 1'b0;
      case (i_opcode)
         OP_LW, OP_I_ALU, OP_R_TYPE: begin
            o_immSrc = IMM_I;
            o_legal  = 1'b1;
         end
         OP_SW: begin
            o_immSrc = IMM_S;
            o_legal  = 1'b1;
         end
         OP_BEQ: begin
            o_immSrc = IMM_B;
            o_legal  = 1'b1;
         end
`ifdef MAIN_FSM_JAL_EN
         OP_JAL: begin
            o_immSrc = IMM_J;
            o_legal  = 1'b1;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/main_fsm.sv
// Multi-cycle control FSM with memory handshake, illegal-opcode flag and a
// retired-instruction counter. Define MAIN_FSM_JAL_EN to support jal.
module main_fsm
   import riscv_ctrl_pkg::*;
#(
   parameter int CNT_W         = 32,
   parameter bit MEM_HANDSHAKE = 1'b1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             PCUpdate,
   output logic             Branch,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             AdrSrc,
   output logic [1:0]       ResultSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       ImmSrc,
   output logic             illegal,
   output logic [CNT_W-1:0] instret
);

   state_t           r_state;
   state_t           w_nextState;
   logic [6:0]       r_opcode;
   logic [CNT_W-1:0] r_instret;
   logic             w_ready;
   logic             w_legal;
   logic             w_retire;

   instr_decoder u_decoder (
      .i_opcode (opcode),
      .o_immSrc (ImmSrc),
      .o_legal  (w_legal)
   );

   assign w_ready  = MEM_HANDSHAKE ? mem_ready : 1'b1;
   assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) || (r_state == S_BEQ) ||
                     ((r_state == S_MEMWRITE) && w_ready);
   assign illegal  = (r_state == S_DECODE) && !w_legal;
   assign instret  = r_instret;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_nextState;
      end
   end

   // The opcode is kept past DECODE so MEMADR can split lw from sw.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_opcode  <= '0;
         r_instret <= '0;
      end else begin
         if (r_state == S_DECODE) r_opcode <= opcode;
         if (w_retire) r_instret <= r_instret + 1'b1;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_FETCH:    if (w_ready) w_nextState = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: w_nextState = S_MEMADR;
               OP_R_TYPE:    w_nextState = S_EXECUTER;
               OP_I_ALU:     w_nextState = S_EXECUTEI;
               OP_BEQ:       w_nextState = S_BEQ;
`ifdef MAIN_FSM_JAL_EN
               OP_JAL:       w_nextState = S_JAL;
`endif
               default:      w_nextState = S_FETCH;
            endcase
         end
         S_MEMADR:   w_nextState = (r_opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (w_ready) w_nextState = S_MEMWB;
         S_MEMWRITE: if (w_ready) w_nextState = S_FETCH;
         S_EXECUTER, S_EXECUTEI: w_nextState = S_ALUWB;
`ifdef MAIN_FSM_JAL_EN
         S_JAL:      w_nextState = S_ALUWB;
`endif
         default:    w_nextState = S_FETCH;
      endcase
   end

   // Moore decode; FETCH alone gates IRWrite/PCUpdate on the memory handshake.
   always_comb begin
      mem_req   = 1'b0;
      PCUpdate  = 1'b0;
      Branch    = 1'b0;
      RegWrite  = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_REG;
      ALUOp     = ALUOP_ADD;
      case (r_state)
         S_FETCH: begin
            mem_req   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            IRWrite   = w_ready;
            PCUpdate  = w_ready;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_REG;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            AdrSrc  = 1'b1;
         end
         S_MEMWRITE: begin
            mem_req  = 1'b1;
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            RegWrite  = 1'b1;
         end
         S_EXECUTER: begin
            ALUSrcA = SRCA_REG;
            ALUOp   = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            ALUSrcA = SRCA_REG;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_FUNCT;
         end
         S_ALUWB:    RegWrite = 1'b1;
         S_BEQ: begin
            ALUSrcA = SRCA_REG;
            ALUOp   = ALUOP_SUB;
            Branch  = 1'b1;
         end
`ifdef MAIN_FSM_JAL_EN
         S_JAL: begin
            ALUSrcA  = SRCA_OLDPC;
            ALUSrcB  = SRCB_FOUR;
            PCUpdate = 1'b1;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_main_fsm.sv
// Table-driven bench for main_fsm plus hand-written reset-abort and counter-wrap
// sequences; a narrow counter is used so wrap-around is reachable quickly.
module tb_main_fsm;

   localparam int CNT_W = 4;

   localparam logic [6:0] LW   = 7'b0000011;
   localparam logic [6:0] SW   = 7'b0100011;
   localparam logic [6:0] RT   = 7'b0110011;
   localparam logic [6:0] IA   = 7'b0010011;
   localparam logic [6:0] BQ   = 7'b1100011;
   localparam logic [6:0] JL   = 7'b1101111;
   localparam logic [6:0] BAD  = 7'b0000000;

   typedef struct {
      logic [6:0]       op;
      logic             rdy;
      logic [17:0]      ctrl;
      logic [CNT_W-1:0] cnt;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [6:0]       opcodeIn;
   logic             readyIn;
   logic             mem_req, PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc, illegal;
   logic [1:0]       ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
   logic [CNT_W-1:0] instret;
   logic [17:0]      actCtrl;

   int checks = 0;
   int errors = 0;

   vec_t vecs[$];

   logic [17:0] eFetchRdy, eFetchWait, eDecode, eDecodeIll, eMemAdr, eMemRead, eMemWrite;
   logic [17:0] eMemWb, eExR, eExI, eAluWb, eBeq, eJal;

   main_fsm #(.CNT_W(CNT_W), .MEM_HANDSHAKE(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .opcode    (opcodeIn),
      .mem_ready (readyIn),
      .mem_req   (mem_req),
      .PCUpdate  (PCUpdate),
      .Branch    (Branch),
      .RegWrite  (RegWrite),
      .MemWrite  (MemWrite),
      .IRWrite   (IRWrite),
      .AdrSrc    (AdrSrc),
      .ResultSrc (ResultSrc),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ALUOp     (ALUOp),
      .ImmSrc    (ImmSrc),
      .illegal   (illegal),
      .instret   (instret)
   );

   always #5 clk = ~clk;

   assign actCtrl = {mem_req, PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc, illegal,
                     ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc};

   function automatic logic [17:0] mk(input logic mreq, pcu, br, rw, mw, irw, adr, ill,
                                      input logic [1:0] res, srcA, srcB, op);
      return {mreq, pcu, br, rw, mw, irw, adr, ill, res, srcA, srcB, op, 2'b00};
   endfunction

   task automatic addRow(input logic [6:0] op, input logic rdy, input logic [17:0] stateVec,
                         input logic [1:0] imm, input logic [CNT_W-1:0] cnt);
      vec_t v;
      v.op   = op;
      v.rdy  = rdy;
      v.ctrl = stateVec | {16'd0, imm};
      v.cnt  = cnt;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input logic [6:0] op, input logic rdy);
      opcodeIn = op;
      readyIn  = rdy;
      #2;
   endtask

   task automatic checkOutput(input string name, input logic [17:0] expCtrl,
                              input logic [CNT_W-1:0] expCnt);
      checks++;
      if (actCtrl !== expCtrl) begin
         errors++;
         $display("[TB] FAIL %s ctrl: got %b expected %b", name, actCtrl, expCtrl);
      end
      checks++;
      if (instret !== expCnt) begin
         errors++;
         $display("[TB] FAIL %s instret: got %0d expected %0d", name, instret, expCnt);
      end
   endtask

   initial begin
      logic [CNT_W-1:0] cntAfterJal;

      eFetchRdy  = mk(1,1,0,0,0,1,0,0, 2'b10, 2'b00, 2'b10, 2'b00);
      eFetchWait = mk(1,0,0,0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00);
      eDecode    = mk(0,0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00);
      eDecodeIll = mk(0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 2'b00);
      eMemAdr    = mk(0,0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00);
      eMemRead   = mk(1,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 2'b00);
      eMemWrite  = mk(1,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 2'b00);
      eMemWb     = mk(0,0,0,1,0,0,0,0, 2'b01, 2'b00, 2'b00, 2'b00);
      eExR       = mk(0,0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10);
      eExI       = mk(0,0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b10);
      eAluWb     = mk(0,0,0,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00);
      eBeq       = mk(0,0,1,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b01);
      eJal       = mk(0,1,0,0,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b00);

      // lw, 5 cycles
      addRow(LW, 1, eFetchRdy, 2'b00, 0);
      addRow(LW, 1, eDecode,   2'b00, 0);
      addRow(LW, 1, eMemAdr,   2'b00, 0);
      addRow(LW, 1, eMemRead,  2'b00, 0);
      addRow(LW, 1, eMemWb,    2'b00, 0);
      // sw with three wait cycles in MEMWRITE
      addRow(SW, 1, eFetchRdy, 2'b01, 1);
      addRow(SW, 1, eDecode,   2'b01, 1);
      addRow(SW, 1, eMemAdr,   2'b01, 1);
      addRow(SW, 0, eMemWrite, 2'b01, 1);
      addRow(SW, 0, eMemWrite, 2'b01, 1);
      addRow(SW, 0, eMemWrite, 2'b01, 1);
      addRow(SW, 1, eMemWrite, 2'b01, 1);
      // beq, R-type, I-ALU back to back
      addRow(BQ, 1, eFetchRdy, 2'b10, 2);
      addRow(BQ, 1, eDecode,   2'b10, 2);
      addRow(BQ, 1, eBeq,      2'b10, 2);
      addRow(RT, 1, eFetchRdy, 2'b00, 3);
      addRow(RT, 1, eDecode,   2'b00, 3);
      addRow(RT, 1, eExR,      2'b00, 3);
      addRow(RT, 1, eAluWb,    2'b00, 3);
      addRow(IA, 1, eFetchRdy, 2'b00, 4);
      addRow(IA, 1, eDecode,   2'b00, 4);
      addRow(IA, 1, eExI,      2'b00, 4);
      addRow(IA, 1, eAluWb,    2'b00, 4);
      // illegal opcode, then FETCH stalls on mem_ready
      addRow(BAD, 1, eFetchRdy,  2'b00, 5);
      addRow(BAD, 1, eDecodeIll, 2'b00, 5);
      addRow(BAD, 0, eFetchWait, 2'b00, 5);
      addRow(BAD, 0, eFetchWait, 2'b00, 5);
      // lw with mem_ready low in DECODE (ignored) and one MEMREAD wait
      addRow(LW, 1, eFetchRdy, 2'b00, 5);
      addRow(LW, 0, eDecode,   2'b00, 5);
      addRow(LW, 1, eMemAdr,   2'b00, 5);
      addRow(LW, 0, eMemRead,  2'b00, 5);
      addRow(LW, 1, eMemRead,  2'b00, 5);
      addRow(LW, 1, eMemWb,    2'b00, 5);
`ifdef MAIN_FSM_JAL_EN
      addRow(JL, 1, eFetchRdy, 2'b11, 6);
      addRow(JL, 1, eDecode,   2'b11, 6);
      addRow(JL, 1, eJal,      2'b11, 6);
      addRow(JL, 1, eAluWb,    2'b11, 6);
      cntAfterJal = 7;
`else
      addRow(JL, 1, eFetchRdy,  2'b00, 6);
      addRow(JL, 1, eDecodeIll, 2'b00, 6);
      addRow(JL, 0, eFetchWait, 2'b00, 6);
      cntAfterJal = 6;
`endif
      addRow(BAD, 0, eFetchWait, 2'b00, cntAfterJal);

      rst      = 1'b1;
      opcodeIn = LW;
      readyIn  = 1'b1;
      #2;
      checkOutput("reset", eFetchRdy, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].op, vecs[i].rdy);
         checkOutput($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].cnt);
         @(negedge clk);
      end

      // Reset in the middle of a stalled MEMREAD aborts the load.
      applyStimulus(LW, 1);
      @(negedge clk);
      applyStimulus(LW, 1);
      @(negedge clk);
      applyStimulus(LW, 1);
      @(negedge clk);
      applyStimulus(LW, 0);
      checkOutput("midMemRead", eMemRead, cntAfterJal);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("asyncReset", eFetchWait, 0);
      @(posedge clk);
      #1;
      checkOutput("resetHeld", eFetchWait, 0);
      @(negedge clk);
      rst = 1'b0;

      // Retire 2^CNT_W R-type instructions to see the counter wrap.
      for (int n = 0; n < 15; n++) begin
         for (int c = 0; c < 4; c++) begin
            applyStimulus(RT, 1);
            @(negedge clk);
         end
      end
      applyStimulus(RT, 1);
      checkOutput("cntMax", eFetchRdy, 4'hF);
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         applyStimulus(RT, 1);
         @(negedge clk);
      end
      applyStimulus(RT, 1);
      checkOutput("cntWrap", eFetchRdy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
